// File: rtl/splitter_ctrl_if.sv
// Byte-stream handshake between a character source and splitter_ctrl.
interface splitter_ctrl_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       eof;

  modport master (
    output char_in,
    output char_valid,
    input  char_ready,
    output eof
  );

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready,
    input  eof
  );
endinterface

// File: rtl/splitter_ctrl.sv
// Feeds grid characters to a beam splitter, drains it for LINE_LENGTH cycles and sums its counts.
// Optional per-run statistics outputs (split_cnt, row_cnt) are enabled by defining SPLITTER_CTRL_STATS_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module splitter_ctrl #(
  parameter int LINE_LENGTH = 141,
  parameter int SUM_WIDTH   = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  splitter_ctrl_if.slave         stream,
  output logic                   spl_en,
  output logic                   spl_split,
  input  logic [`DATA_WIDTH-1:0] spl_count,
  output logic [SUM_WIDTH-1:0]   sum_out,
  output logic                   done,
  output logic                   err_len
`ifdef SPLITTER_CTRL_STATS_EN
  ,
  output logic [31:0]            split_cnt,
  output logic [31:0]            row_cnt
`endif
);

  localparam int COL_W = $clog2(LINE_LENGTH + 2);
  localparam int DRN_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;

  localparam logic [COL_W-1:0] COL_FULL = COL_W'(LINE_LENGTH);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(LINE_LENGTH + 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LINE_LENGTH - 1);

  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_CARET = 8'h5E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [COL_W-1:0]     col_p0, col_d;
  logic [DRN_W-1:0]     drain_p0, drain_d;
  logic                 err_p0, err_d;
  logic                 en_p1, en_d;
  logic                 split_p1, split_d;
  logic [SUM_WIDTH-1:0] sum_p1, sum_d;

  logic accept;
  logic start_run;
  logic is_nl;
  logic is_cr;
  logic is_caret;

  // Modulo-2^SUM_WIDTH accumulate; the count is unsigned and zero-extended.
  function automatic logic [SUM_WIDTH-1:0] acc_wrap(
    input logic [SUM_WIDTH-1:0]   acc,
    input logic [`DATA_WIDTH-1:0] cnt
  );
    return acc + SUM_WIDTH'(cnt);
  endfunction

  assign accept    = stream.char_valid && (state_q == FEED);
  assign start_run = start && ((state_q == IDLE) || (state_q == DONE));
  assign is_nl     = (stream.char_in == CH_NL);
  assign is_cr     = (stream.char_in == CH_CR);
  assign is_caret  = (stream.char_in == CH_CARET);

  // Stage p0: decode the accepted byte / drain step into next-cycle splitter controls.
  always_comb begin
    state_d = state_q;
    col_d   = col_p0;
    drain_d = drain_p0;
    err_d   = err_p0;
    en_d    = 1'b0;
    split_d = 1'b0;
    sum_d   = sum_p1;

    case (state_q)
      IDLE: begin
        if (start_run) begin
          state_d = FEED;
          col_d   = '0;
          drain_d = '0;
        end
      end

      FEED: begin
        if (accept) begin
          if (is_nl) begin
            if (col_p0 != COL_FULL) err_d = 1'b1;
            col_d = '0;
          end else if (!is_cr) begin
            en_d    = 1'b1;
            split_d = is_caret;
            if (col_p0 >= COL_FULL) err_d = 1'b1;
            // Saturate one past the row length so an overlong row cannot wrap back to legal.
            if (col_p0 != COL_MAX) col_d = col_p0 + COL_W'(1);
          end
        end else if (stream.eof) begin
          state_d = DRAIN;
          drain_d = '0;
          en_d    = 1'b1;
        end
      end

      DRAIN: begin
        sum_d = acc_wrap(sum_p1, spl_count);
        if (drain_p0 == DRN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_p0 + DRN_W'(1);
          en_d    = 1'b1;
        end
      end

      DONE: begin
        if (start_run) begin
          state_d = FEED;
          sum_d   = '0;
          err_d   = 1'b0;
          col_d   = '0;
          drain_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Stage p1: registered splitter drive, row bookkeeping and the running sum.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_p0   <= '0;
      drain_p0 <= '0;
      err_p0   <= 1'b0;
      en_p1    <= 1'b0;
      split_p1 <= 1'b0;
      sum_p1   <= '0;
    end else begin
      col_p0   <= col_d;
      drain_p0 <= drain_d;
      err_p0   <= err_d;
      en_p1    <= en_d;
      split_p1 <= split_d;
      sum_p1   <= sum_d;
    end
  end

  assign stream.char_ready = (state_q == FEED);
  assign spl_en            = en_p1;
  assign spl_split         = split_p1;
  assign sum_out           = sum_p1;
  assign err_len           = err_p0;
  assign done              = (state_q == DONE);

`ifdef SPLITTER_CTRL_STATS_EN
  logic [31:0] split_cnt_q;
  logic [31:0] row_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n || start_run) begin
      split_cnt_q <= '0;
      row_cnt_q   <= '0;
    end else if (accept) begin
      if (is_caret) split_cnt_q <= split_cnt_q + 32'd1;
      if (is_nl)    row_cnt_q   <= row_cnt_q + 32'd1;
    end
  end

  assign split_cnt = split_cnt_q;
  assign row_cnt   = row_cnt_q;
`endif

endmodule
